// File: rtl/grf_wb_queue.sv
// Write-back queue in front of the register file's single write port.
// Drains in order, one entry per cycle, and forwards the youngest pending value per lookup port.
module grf_wb_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [4:0]    in_addr,
   input  logic [31:0]   in_data,
   input  logic [31:0]   in_pc,
   input  logic          wb_stall,
   output logic          RegWrite,
   output logic [4:0]    WA,
   output logic [31:0]   WD,
   output logic [31:0]   PC,
   input  logic [4:0]    lk_addr1,
   input  logic [4:0]    lk_addr2,
   output logic          lk_hit1,
   output logic          lk_hit2,
   output logic [31:0]   lk_data1,
   output logic [31:0]   lk_data2,
   output logic [CW-1:0] count,
   output logic          empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [4:0]    mem_addr [DEPTH];
   logic [31:0]   mem_data [DEPTH];
   logic [31:0]   mem_pc   [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count_q;
   logic          do_enq;

   // Handshake: a write-back transfers at a posedge where in_valid && in_ready.
   // in_ready depends only on reset and the registered count, so a full queue
   // never accepts, even when the head drains in that same cycle.
   assign count    = count_q;
   assign empty    = (count_q == '0);
   assign in_ready = !reset && (count_q != CW'(DEPTH));
   assign RegWrite = !reset && !empty && !wb_stall;
   // Writes to $0 complete the handshake but are never stored.
   assign do_enq   = in_valid && in_ready && (in_addr != 5'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (do_enq)   tail <= tail + AW'(1);
         if (RegWrite) head <= head + AW'(1);
         case ({do_enq, RegWrite})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_enq) begin
         mem_addr[tail] <= in_addr;
         mem_data[tail] <= in_data;
         mem_pc[tail]   <= in_pc;
      end
   end

   assign WA = RegWrite ? mem_addr[head] : 5'd0;
   assign WD = RegWrite ? mem_data[head] : 32'd0;
   assign PC = RegWrite ? mem_pc[head]   : 32'd0;

   // Scan oldest to youngest so the last match (closest to tail) wins.
   always_comb begin
      logic [AW-1:0] idx;
      lk_hit1  = 1'b0;
      lk_hit2  = 1'b0;
      lk_data1 = 32'd0;
      lk_data2 = 32'd0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + AW'(i);
         if (!reset && (CW'(i) < count_q)) begin
            if ((lk_addr1 != 5'd0) && (mem_addr[idx] == lk_addr1)) begin
               lk_hit1  = 1'b1;
               lk_data1 = mem_data[idx];
            end
            if ((lk_addr2 != 5'd0) && (mem_addr[idx] == lk_addr2)) begin
               lk_hit2  = 1'b1;
               lk_data2 = mem_data[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_grf_wb_queue.sv
// Bench for grf_wb_queue: directed scenarios plus random traffic, checked against
// a queue-based reference model and a write-order scoreboard.
module tb_grf_wb_queue;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int W     = 69;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [4:0]    in_addr = '0;
   logic [31:0]   in_data = '0;
   logic [31:0]   in_pc = '0;
   logic          wb_stall = 1'b0;
   logic          RegWrite;
   logic [4:0]    WA;
   logic [31:0]   WD;
   logic [31:0]   PC;
   logic [4:0]    lk_addr1 = '0;
   logic [4:0]    lk_addr2 = '0;
   logic          lk_hit1, lk_hit2;
   logic [31:0]   lk_data1, lk_data2;
   logic [CW-1:0] count;
   logic          empty;

   int checks = 0;
   int errors = 0;
   bit run_chk = 1'b0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mdl_q[$];

   grf_wb_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .in_pc(in_pc), .wb_stall(wb_stall),
      .RegWrite(RegWrite), .WA(WA), .WD(WD), .PC(PC),
      .lk_addr1(lk_addr1), .lk_addr2(lk_addr2), .lk_hit1(lk_hit1), .lk_hit2(lk_hit2),
      .lk_data1(lk_data1), .lk_data2(lk_data2), .count(count), .empty(empty)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // youngest pending value for a register, from the model's pending list
   function automatic logic [32:0] mdl_lookup(input logic [4:0] a);
      if (a == 5'd0) return 33'd0;
      for (int i = mdl_q.size() - 1; i >= 0; i--)
         if (mdl_q[i][68:64] == a) return {1'b1, mdl_q[i][63:32]};
      return 33'd0;
   endfunction

   // reference model: compare this cycle, then advance to the post-edge state
   always @(negedge clk) begin
      if (run_chk) begin
         logic exp_rw, exp_rdy;
         logic [32:0] l1, l2;
         exp_rdy = !reset && (mdl_q.size() != DEPTH);
         exp_rw  = !reset && (mdl_q.size() != 0) && !wb_stall;
         l1 = reset ? 33'd0 : mdl_lookup(lk_addr1);
         l2 = reset ? 33'd0 : mdl_lookup(lk_addr2);
         chk("count", 32'(count), 32'(mdl_q.size()));
         chk("empty", 32'(empty), 32'(mdl_q.size() == 0));
         chk("in_ready", 32'(in_ready), 32'(exp_rdy));
         chk("regwrite", 32'(RegWrite), 32'(exp_rw));
         chk("lk1", {31'd0, lk_hit1} ^ lk_data1, {31'd0, l1[32]} ^ l1[31:0]);
         chk("lk2", {31'd0, lk_hit2} ^ lk_data2, {31'd0, l2[32]} ^ l2[31:0]);
         if (!exp_rw) chk("idle_outputs", {27'd0, WA} | WD | PC, 32'd0);
         if (reset) begin
            mdl_q.delete();
            exp_q.delete();
         end else begin
            if (exp_rw) void'(mdl_q.pop_front());
            if (in_valid && exp_rdy && in_addr != 5'd0) begin
               mdl_q.push_back({in_addr, in_data, in_pc});
               exp_q.push_back({in_addr, in_data, in_pc});
            end
         end
      end
   end

   // scoreboard monitor: every write strobe must match the next expected write
   always @(negedge clk) begin
      if (run_chk && RegWrite === 1'b1) begin
         logic [W-1:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: WA=%0d WD=0x%08h PC=0x%08h with nothing pending", WA, WD, PC);
         end else begin
            e = exp_q.pop_front();
            if ({WA, WD, PC} !== e) begin
               errors++;
               $display("FAIL write_order: got %0d/0x%08h/0x%08h expected %0d/0x%08h/0x%08h",
                        WA, WD, PC, e[68:64], e[63:32], e[31:0]);
            end
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
      int n = 0;
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      in_pc    = p;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready=%0b expected 1 within 50 cycles", in_ready);
            break;
         end
      end
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      step();
      run_chk = 1'b1;
      step();
      reset = 1'b0;

      // reset then single write
      @(negedge clk);
      chk("ready_after_reset", 32'(in_ready), 32'd1);
      step();
      push(5'd8, 32'h1234, 32'h3000);
      @(negedge clk);
      chk("single_wa", 32'(WA), 32'd8);
      chk("single_wd", WD, 32'h1234);
      chk("single_pc", PC, 32'h3000);
      chk("single_count", 32'(count), 32'd1);
      step();
      @(negedge clk);
      chk("single_empty", 32'(empty), 32'd1);
      step();

      // fill under stall, fifth waits until the stall lifts
      wb_stall = 1'b1;
      fork
         for (int i = 1; i <= 5; i++) push(5'(i), 32'(i * 'h11), 32'h4000 + 32'(i * 4));
         begin
            repeat (7) step();
            chk("full_count", 32'(count), 32'(DEPTH));
            wb_stall = 1'b0;
         end
      join
      repeat (6) step();

      // $0 filter
      lk_addr1 = 5'd0;
      push(5'd0, 32'hFFFF_FFFF, 32'h5000);
      @(negedge clk);
      chk("zero_count", 32'(count), 32'd0);
      chk("zero_hit", 32'(lk_hit1), 32'd0);
      step();

      // youngest forwarding
      wb_stall = 1'b1;
      push(5'd5, 32'hA, 32'h6000);
      push(5'd7, 32'hB, 32'h6004);
      push(5'd5, 32'hC, 32'h6008);
      lk_addr1 = 5'd5;
      lk_addr2 = 5'd9;
      @(negedge clk);
      chk("fwd_young", lk_data1, 32'hC);
      chk("fwd_miss_hit", 32'(lk_hit2), 32'd0);
      step();
      wb_stall = 1'b0;
      step();
      @(negedge clk);
      chk("fwd_after_drain", lk_data1, 32'hC);
      repeat (3) step();
      chk("fwd_gone", 32'(lk_hit1), 32'd0);

      // simultaneous enqueue/drain at full, then streaming across the wrap
      wb_stall = 1'b1;
      for (int i = 0; i < DEPTH; i++) push(5'(10 + i), 32'h100 + 32'(i), 32'h7000 + 32'(i));
      wb_stall = 1'b0;
      in_valid = 1'b1;
      in_addr  = 5'd20;
      in_data  = 32'h200;
      in_pc    = 32'h7100;
      @(negedge clk);
      chk("full_no_pass", 32'(in_ready), 32'd0);
      step();
      @(negedge clk);
      chk("full_then_count", 32'(count), 32'(DEPTH - 1));
      chk("full_then_ready", 32'(in_ready), 32'd1);
      step();
      for (int i = 0; i < 10; i++) push(5'(21 + i % 8), 32'h300 + 32'(i), 32'h7200 + 32'(i));
      repeat (6) step();

      // reset mid-operation discards pending writes
      wb_stall = 1'b1;
      push(5'd3, 32'hDEAD, 32'h8000);
      push(5'd4, 32'hBEEF, 32'h8004);
      push(5'd6, 32'hCAFE, 32'h8008);
      wb_stall = 1'b0;
      reset    = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("midreset_count", 32'(count), 32'd0);
      repeat (4) step();

      // random traffic
      for (int c = 0; c < 600; c++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_addr  = 5'($urandom_range(0, 7));
         in_data  = $urandom;
         in_pc    = $urandom;
         wb_stall = ($urandom_range(0, 3) == 0);
         lk_addr1 = 5'($urandom_range(0, 7));
         lk_addr2 = 5'($urandom_range(0, 7));
         reset    = ($urandom_range(0, 99) == 0);
         step();
      end
      in_valid = 1'b0;
      wb_stall = 1'b0;
      reset    = 1'b0;
      repeat (DEPTH + 2) step();
      chk("all_written", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
